// File: rtl/fir_pkg.sv
// Shared widths, FSM state encoding and the tap-count headroom check for the
// serial FIR multiply-accumulate engine.
package fir_pkg;

   localparam int FIR_DATA_WIDTH  = 16;
   localparam int FIR_DATA_FRAC   = 15;
   localparam int FIR_COEFF_WIDTH = 20;
   localparam int FIR_COEFF_FRAC  = 17;
   localparam int FIR_PROD_WIDTH  = FIR_DATA_WIDTH + FIR_COEFF_WIDTH - 1;
   localparam int FIR_PROD_FRAC   = FIR_DATA_FRAC + FIR_COEFF_FRAC;
   localparam int FIR_ACC_WIDTH   = 42;
   localparam int FIR_ACC_FRAC    = FIR_PROD_FRAC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // The accumulator guard bits must cover the worst-case sum of N_TAPS products.
   function automatic bit taps_ok(input int n_taps, input int acc_w, input int prod_w);
      return (n_taps >= 2) && (n_taps <= (1 << (acc_w - prod_w)));
   endfunction

endpackage

// File: rtl/fir_coeff_regfile.sv
// Coefficient storage: one write port locked out while the engine is busy,
// a combinational read port indexed by the current tap.
module fir_coeff_regfile #(
   parameter int N_TAPS      = 72,
   parameter int COEFF_WIDTH = 20,
   parameter int ADDR_WIDTH  = $clog2(N_TAPS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          busy,
   input  logic                          we,
   input  logic [ADDR_WIDTH-1:0]         waddr,
   input  logic signed [COEFF_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0]         raddr,
   output logic signed [COEFF_WIDTH-1:0] rdata,
   output logic                          err
);

   logic signed [COEFF_WIDTH-1:0] coeffs [N_TAPS];
   logic                          in_range;
   logic                          write_ok;

   always_comb begin
      in_range = 32'(waddr) < N_TAPS;
      write_ok = we && !busy && in_range;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_TAPS; i++) coeffs[i] <= '0;
         err <= 1'b0;
      end else begin
         if (write_ok) coeffs[waddr] <= wdata;
         err <= we && !write_ok;
      end
   end

   assign rdata = coeffs[raddr];

endmodule

// File: rtl/fir_serial_mac.sv
// Single-multiplier FIR: one accepted sample triggers N_TAPS serial MAC cycles
// into a full-precision accumulator, then a one-cycle result pulse.
module fir_serial_mac
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH  = FIR_DATA_WIDTH,
   parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
   parameter int PROD_WIDTH  = DATA_WIDTH + COEFF_WIDTH - 1,
   parameter int ACC_WIDTH   = FIR_ACC_WIDTH,
   parameter int N_TAPS      = 72
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic signed [DATA_WIDTH-1:0]  in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          coeff_we,
   input  logic [$clog2(N_TAPS)-1:0]     coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_data,
   output logic                          coeff_err,
   output logic signed [ACC_WIDTH-1:0]   acc_out,
   output logic                          acc_valid
);

   localparam int                   TAP_WIDTH = $clog2(N_TAPS);
   localparam logic [TAP_WIDTH-1:0] LAST_TAP  = TAP_WIDTH'(N_TAPS - 1);

   if (!taps_ok(N_TAPS, ACC_WIDTH, PROD_WIDTH)) begin : g_bad_taps
      $error("fir_serial_mac: N_TAPS exceeds accumulator headroom or is below 2");
   end

   function automatic logic signed [PROD_WIDTH-1:0] mul(
      input logic signed [COEFF_WIDTH-1:0] c,
      input logic signed [DATA_WIDTH-1:0]  x
   );
      logic signed [PROD_WIDTH-1:0] cw;
      logic signed [PROD_WIDTH-1:0] xw;
      cw = PROD_WIDTH'(c);
      xw = PROD_WIDTH'(x);
      return cw * xw;
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] ext(input logic signed [PROD_WIDTH-1:0] p);
      return ACC_WIDTH'(p);
   endfunction

   state_t                         state;
   state_t                         state_nxt;
   logic                           accept;
   logic                           busy;
   logic [TAP_WIDTH-1:0]           tap;
   logic signed [DATA_WIDTH-1:0]   x_line [N_TAPS];
   logic signed [COEFF_WIDTH-1:0]  coeff_tap;
   logic signed [PROD_WIDTH-1:0]   prod_p1;
   logic                           vld_p1;
   logic signed [ACC_WIDTH-1:0]    acc_p2;

   fir_coeff_regfile #(
      .N_TAPS      (N_TAPS),
      .COEFF_WIDTH (COEFF_WIDTH),
      .ADDR_WIDTH  (TAP_WIDTH)
   ) u_coeffs (
      .clk   (clk),
      .rst_n (rst_n),
      .busy  (busy),
      .we    (coeff_we),
      .waddr (coeff_addr),
      .wdata (coeff_data),
      .raddr (tap),
      .rdata (coeff_tap),
      .err   (coeff_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MAC;
         MAC:     if (tap == LAST_TAP) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = !in_ready;
      accept   = in_valid && in_ready;
   end

   // Control, delay line and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap       <= '0;
         vld_p1    <= 1'b0;
         acc_valid <= 1'b0;
         acc_out   <= '0;
         for (int k = 0; k < N_TAPS; k++) x_line[k] <= '0;
      end else begin
         vld_p1    <= (state == MAC);
         acc_valid <= (state == FLUSH);
         if (accept) begin
            tap <= '0;
            for (int k = N_TAPS - 1; k > 0; k--) x_line[k] <= x_line[k-1];
            x_line[0] <= in_data;
         end else if (state == MAC) begin
            tap <= tap + 1'b1;
         end
         if (state == FLUSH) acc_out <= acc_p2 + ext(prod_p1);
      end
   end

   // Stage p1: product register; stage p2: accumulator lags the product by one cycle
   always_ff @(posedge clk) begin
      if (state == MAC) prod_p1 <= mul(coeff_tap, x_line[tap]);
      if (accept)                      acc_p2 <= '0;
      else if (state == MAC && vld_p1) acc_p2 <= acc_p2 + ext(prod_p1);
   end

endmodule
